bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3
// (double-dabble) method, one input bit per clock.
//
// A value is accepted in IDLE and then shifted for exactly IN_W cycles in
// SHIFT. A 5-digit scratch register holds the intermediate result, so values
// above 9999 can be detected. Such values saturate the 4-digit output to 9999
// and raise ovf. bcd_out/ovf change only on the edge that completes a
// conversion, so intermediate scratch contents are never visible.
module bin2bcd_seq #(
    parameter int IN_W = 16
) (
    input  logic            clk_100mhz,
    input  logic            reset,
    input  logic [IN_W-1:0] bin_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [15:0]     bcd_out,
    output logic            ovf,
    output logic            out_valid
);

    // The counter must hold IN_W-1 without wrapping for every legal IN_W.
    localparam int                CNT_W    = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IN_W - 1);
    localparam int                NDIG     = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IN_W-1:0]         r_shift;
    logic [IN_W-1:0]         w_shift_next;
    logic [4*NDIG-1:0]       r_scratch;
    logic [4*NDIG-1:0]       w_scratch_next;
    logic [4*NDIG-1:0]       w_scratch_adj;
    logic [4*NDIG-1:0]       w_scratch_shifted;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [15:0]             r_bcd;
    logic [15:0]             w_bcd_next;
    logic                    r_ovf;
    logic                    w_ovf_next;
    logic                    r_out_valid;
    logic                    w_out_valid_next;
    logic                    w_last;
    logic                    w_unused_top;

    // Add-3 correction for each scratch digit that would reach 10 or more
    // after doubling. Every digit stays within 0..9 before correction, so the
    // corrected value (at most 12) always fits in 4 bits.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit_adj
            assign w_scratch_adj[gi*4 +: 4] =
                (r_scratch[gi*4 +: 4] >= 4'd5) ? (r_scratch[gi*4 +: 4] + 4'd3)
                                               : r_scratch[gi*4 +: 4];
        end
    endgenerate

    // Shift the corrected scratch left one bit. The next binary MSB enters
    // at the bottom of the scratch.
    assign w_scratch_shifted = {w_scratch_adj[4*NDIG-2:0], r_shift[IN_W-1]};

    // The MSB shifted out of the scratch is always zero because the result
    // fits in 5 digits.
    assign w_unused_top = w_scratch_adj[4*NDIG-1];

    // This is the final shift of the current conversion.
    assign w_last = (r_cnt == LAST_CNT);

    // Next-state and datapath update logic.
    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_scratch_next   = r_scratch;
        w_cnt_next       = r_cnt;
        w_bcd_next       = r_bcd;
        w_ovf_next       = r_ovf;
        w_out_valid_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_shift_next   = bin_in;
                    w_scratch_next = '0;
                    w_cnt_next     = '0;
                    w_state_next   = SHIFT;
                end
            end

            SHIFT: begin
                w_shift_next   = {r_shift[IN_W-2:0], 1'b0};
                w_scratch_next = w_scratch_shifted;
                w_cnt_next     = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_state_next     = IDLE;
                    w_out_valid_next = 1'b1;
                    if (w_scratch_shifted[4*NDIG-1:16] != 4'd0) begin
                        w_bcd_next = 16'h9999;
                        w_ovf_next = 1'b1;
                    end else begin
                        w_bcd_next = w_scratch_shifted[15:0];
                        w_ovf_next = 1'b0;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any conversion in progress.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_scratch   <= '0;
            r_cnt       <= '0;
            r_bcd       <= 16'h0000;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_scratch   <= w_scratch_next;
            r_cnt       <= w_cnt_next;
            r_bcd       <= w_bcd_next;
            r_ovf       <= w_ovf_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign bcd_out   = r_bcd;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule
